// File: rtl/pipe_credit_buffer.sv
// -----------------------------------------------------------------------------
// pipe_credit_buffer
//
// Credit-managed output buffer at the tail of a fixed-latency pipeline.
// A launch into the pipeline is granted only while a buffer slot can be
// reserved for its result. The reservation covers both the samples already in
// the buffer and the samples still travelling down the pipeline. Because of
// this, a well-behaved pipeline can never overflow the buffer.
//
// Ports
//   clk           : single clock, rising edge
//   rst           : synchronous, active-high reset
//   issueReq      : upstream asks to launch one sample
//   issueGrant    : launch permitted this cycle (combinational)
//   pipeValid     : pipeline tail valid
//   pipeData      : pipeline tail data, qualified by pipeValid
//   outValid      : buffer head holds a sample (registered state only)
//   outData       : buffer head sample (registered state only)
//   outReady      : consumer takes the head this cycle
//   credits       : free credits, DEPTH - reserved
//   protocolError : sticky flag, set by an unexpected or overflowing pipeValid
// -----------------------------------------------------------------------------
module pipe_credit_buffer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issueReq,
  output logic                       issueGrant,
  input  logic                       pipeValid,
  input  logic [WIDTH-1:0]           pipeData,
  output logic                       outValid,
  output logic [WIDTH-1:0]           outData,
  input  logic                       outReady,
  output logic [$clog2(DEPTH+1)-1:0] credits,
  output logic                       protocolError
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = $clog2(DEPTH);

  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
  localparam logic [CntW-1:0] OneCnt   = CntW'(1);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(DEPTH - 1);
  localparam logic [PtrW-1:0] OnePtr   = PtrW'(1);

  // Counter and pointer state
  logic [CntW-1:0] reserved_q, reserved_d;
  logic [CntW-1:0] in_flight_q, in_flight_d;
  logic [CntW-1:0] occupancy_q, occupancy_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic            error_q, error_d;

  // Storage is deliberately not reset. The occupancy count alone decides
  // what is valid.
  logic [WIDTH-1:0] mem [DEPTH];

  // Per-cycle events
  logic grant;
  logic push;
  logic pop;
  logic violation;

  always_comb begin
    // A pop in this cycle frees a credit only from the next cycle on. This
    // keeps issueGrant from depending on outReady.
    grant = issueReq && (reserved_q < DepthCnt);

    pop = (occupancy_q != '0) && outReady;

    // A sample is accepted only if it has a room in the buffer and an owner.
    // The owner is either an earlier grant still in flight or a grant in
    // this same cycle, which covers a zero-latency pipeline.
    push = pipeValid && (occupancy_q < DepthCnt) && ((in_flight_q != '0) || grant);

    violation = pipeValid && !push;
  end

  always_comb begin
    reserved_d = reserved_q;
    if (grant && !pop) begin
      reserved_d = reserved_q + OneCnt;
    end else if (pop && !grant) begin
      reserved_d = reserved_q - OneCnt;
    end

    in_flight_d = in_flight_q;
    if (grant && !push) begin
      in_flight_d = in_flight_q + OneCnt;
    end else if (push && !grant) begin
      in_flight_d = in_flight_q - OneCnt;
    end

    // With occupancy 0 no pop is possible, so push+pop only ever happens
    // with occupancy in 1..DEPTH-1 and leaves the count unchanged.
    occupancy_d = occupancy_q;
    if (push && !pop) begin
      occupancy_d = occupancy_q + OneCnt;
    end else if (pop && !push) begin
      occupancy_d = occupancy_q - OneCnt;
    end

    // The explicit wrap lets DEPTH be any value in range.
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + OnePtr;
    end

    rd_ptr_d = rd_ptr_q;
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + OnePtr;
    end

    error_d = error_q || violation;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reserved_q  <= '0;
      in_flight_q <= '0;
      occupancy_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      error_q     <= 1'b0;
    end else begin
      reserved_q  <= reserved_d;
      in_flight_q <= in_flight_d;
      occupancy_q <= occupancy_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      error_q     <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= pipeData;
    end
  end

  always_comb begin
    issueGrant    = grant;
    outValid      = (occupancy_q != '0);
    outData       = mem[rd_ptr_q];
    credits       = DepthCnt - reserved_q;
    protocolError = error_q;
  end

endmodule

// File: tb/tb_pipe_credit_buffer.sv
module tb_pipe_credit_buffer;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             issueReq = 1'b0;
  logic             issueGrant;
  logic             pipeValid = 1'b0;
  logic [WIDTH-1:0] pipeData = '0;
  logic             outValid;
  logic [WIDTH-1:0] outData;
  logic             outReady = 1'b0;
  logic [3:0]       credits;
  logic             protocolError;

  int tests_run = 0;
  int tests_failed = 0;

  pipe_credit_buffer #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .issueReq     (issueReq),
    .issueGrant   (issueGrant),
    .pipeValid    (pipeValid),
    .pipeData     (pipeData),
    .outValid     (outValid),
    .outData      (outData),
    .outReady     (outReady),
    .credits      (credits),
    .protocolError(protocolError)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issueReq  = 1'b0;
    pipeValid = 1'b0;
    pipeData  = '0;
    outReady  = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    tests_run++;
    if (outValid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out_valid got=%b exp=0", outValid);
    end
    tests_run++;
    if (credits !== 4'd8) begin
      tests_failed++;
      $display("FAIL reset_credits got=%0d exp=8", credits);
    end
    tests_run++;
    if (issueGrant !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_grant got=%b exp=0", issueGrant);
    end
    tests_run++;
    if (protocolError !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_error got=%b exp=0", protocolError);
    end
  endtask

  task automatic test_basic();
    issueReq = 1'b1;
    #1;
    tests_run++;
    if (issueGrant !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_grant got=%b exp=1", issueGrant);
    end
    cyc();
    issueReq = 1'b0;
    #1;
    tests_run++;
    if (credits !== 4'd7) begin
      tests_failed++;
      $display("FAIL basic_credits_after_grant got=%0d exp=7", credits);
    end
    cyc();
    cyc();
    pipeValid = 1'b1;
    pipeData  = 16'h00A5;
    outReady  = 1'b1;
    #1;
    tests_run++;
    if (outValid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_out_valid_early got=%b exp=0", outValid);
    end
    cyc();
    pipeValid = 1'b0;
    pipeData  = '0;
    #1;
    tests_run++;
    if (outValid !== 1'b1 || outData !== 16'h00A5) begin
      tests_failed++;
      $display("FAIL basic_head got=%b/%h exp=1/00a5", outValid, outData);
    end
    tests_run++;
    if (credits !== 4'd7) begin
      tests_failed++;
      $display("FAIL basic_credits_held got=%0d exp=7", credits);
    end
    cyc();
    outReady = 1'b0;
    #1;
    tests_run++;
    if (outValid !== 1'b0 || credits !== 4'd8) begin
      tests_failed++;
      $display("FAIL basic_after_pop got=%b/%0d exp=0/8", outValid, credits);
    end
  endtask

  task automatic test_exhaust();
    int grants = 0;
    outReady = 1'b0;
    for (int i = 0; i < 10; i++) begin
      issueReq = 1'b1;
      #1;
      if (issueGrant === 1'b1) grants++;
      cyc();
    end
    #1;
    tests_run++;
    if (grants != 8) begin
      tests_failed++;
      $display("FAIL exhaust_grant_count got=%0d exp=8", grants);
    end
    tests_run++;
    if (issueGrant !== 1'b0 || credits !== 4'd0) begin
      tests_failed++;
      $display("FAIL exhaust_stalled got=%b/%0d exp=0/0", issueGrant, credits);
    end
    issueReq = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pipeValid = 1'b1;
      pipeData  = 16'h0010 + 16'(i);
      cyc();
    end
    pipeValid = 1'b0;
    pipeData  = '0;
    #1;
    tests_run++;
    if (outValid !== 1'b1 || protocolError !== 1'b0 || credits !== 4'd0) begin
      tests_failed++;
      $display("FAIL exhaust_full got=%b/%b/%0d exp=1/0/0", outValid, protocolError, credits);
    end
  endtask

  // Continues from the full buffer left by test_exhaust.
  task automatic test_full_pop_grant();
    outReady = 1'b1;
    issueReq = 1'b1;
    #1;
    tests_run++;
    if (issueGrant !== 1'b0 || credits !== 4'd0 || outData !== 16'h0010) begin
      tests_failed++;
      $display("FAIL fullpop_same_cycle got=%b/%0d/%h exp=0/0/0010",
               issueGrant, credits, outData);
    end
    cyc();
    outReady = 1'b0;
    #1;
    tests_run++;
    if (issueGrant !== 1'b1 || credits !== 4'd1) begin
      tests_failed++;
      $display("FAIL fullpop_next_grant got=%b/%0d exp=1/1", issueGrant, credits);
    end
    cyc();
    issueReq = 1'b0;
    #1;
    tests_run++;
    if (credits !== 4'd0) begin
      tests_failed++;
      $display("FAIL fullpop_credits_back got=%0d exp=0", credits);
    end
    pipeValid = 1'b1;
    pipeData  = 16'h0100;
    cyc();
    pipeValid = 1'b0;
    pipeData  = '0;
    outReady  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [15:0] e;
      e = (i < 7) ? 16'h0011 + 16'(i) : 16'h0100;
      #1;
      tests_run++;
      if (outValid !== 1'b1 || outData !== e) begin
        tests_failed++;
        $display("FAIL fullpop_drain[%0d] got=%b/%h exp=1/%h", i, outValid, outData, e);
      end
      cyc();
    end
    outReady = 1'b0;
    #1;
    tests_run++;
    if (outValid !== 1'b0 || credits !== 4'd8 || protocolError !== 1'b0) begin
      tests_failed++;
      $display("FAIL fullpop_empty got=%b/%0d/%b exp=0/8/0", outValid, credits, protocolError);
    end
  endtask

  // Bench-side pipeline of latency 3 driven by observed grants.
  task automatic test_wrap();
    logic        dl_v [3];
    logic [15:0] dl_d [3];
    int issued = 0;
    int recv = 0;
    for (int k = 0; k < 3; k++) begin
      dl_v[k] = 1'b0;
      dl_d[k] = '0;
    end
    for (int c = 0; c < 400 && recv < 20; c++) begin
      logic g;
      issueReq  = (issued < 20);
      outReady  = 1'($urandom_range(0, 1));
      pipeValid = dl_v[2];
      pipeData  = dl_d[2];
      #1;
      g = issueGrant;
      if (outValid === 1'b1 && outReady) begin
        tests_run++;
        if (outData !== 16'(recv + 1)) begin
          tests_failed++;
          $display("FAIL wrap_order[%0d] got=%h exp=%h", recv, outData, 16'(recv + 1));
        end
        recv++;
      end
      dl_v[2] = dl_v[1];
      dl_d[2] = dl_d[1];
      dl_v[1] = dl_v[0];
      dl_d[1] = dl_d[0];
      dl_v[0] = g;
      dl_d[0] = g ? 16'(issued + 1) : 16'h0;
      if (g) issued++;
      cyc();
    end
    idle_inputs();
    #1;
    tests_run++;
    if (recv != 20) begin
      tests_failed++;
      $display("FAIL wrap_count got=%0d exp=20", recv);
    end
    tests_run++;
    if (protocolError !== 1'b0 || credits !== 4'd8 || outValid !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_final got=%b/%0d/%b exp=0/8/0", protocolError, credits, outValid);
    end
  endtask

  // Grant and pipeValid in one cycle with nothing in flight is legal.
  task automatic test_same_cycle();
    issueReq  = 1'b1;
    pipeValid = 1'b1;
    pipeData  = 16'h0077;
    cyc();
    idle_inputs();
    #1;
    tests_run++;
    if (outValid !== 1'b1 || outData !== 16'h0077 || credits !== 4'd7 ||
        protocolError !== 1'b0) begin
      tests_failed++;
      $display("FAIL same_cycle got=%b/%h/%0d/%b exp=1/0077/7/0",
               outValid, outData, credits, protocolError);
    end
    outReady = 1'b1;
    cyc();
    outReady = 1'b0;
    #1;
    tests_run++;
    if (outValid !== 1'b0 || credits !== 4'd8) begin
      tests_failed++;
      $display("FAIL same_cycle_pop got=%b/%0d exp=0/8", outValid, credits);
    end
  endtask

  task automatic test_violation();
    pipeValid = 1'b1;
    pipeData  = 16'hDEAD;
    cyc();
    idle_inputs();
    #1;
    tests_run++;
    if (protocolError !== 1'b1 || outValid !== 1'b0 || credits !== 4'd8) begin
      tests_failed++;
      $display("FAIL viol_drop got=%b/%b/%0d exp=1/0/8", protocolError, outValid, credits);
    end
    cyc();
    cyc();
    issueReq = 1'b1;
    cyc();
    issueReq = 1'b0;
    cyc();
    cyc();
    pipeValid = 1'b1;
    pipeData  = 16'h0042;
    cyc();
    pipeValid = 1'b0;
    pipeData  = '0;
    #1;
    tests_run++;
    if (outValid !== 1'b1 || outData !== 16'h0042 || protocolError !== 1'b1) begin
      tests_failed++;
      $display("FAIL viol_after_traffic got=%b/%h/%b exp=1/0042/1",
               outValid, outData, protocolError);
    end
    outReady = 1'b1;
    cyc();
    outReady = 1'b0;
    #1;
    tests_run++;
    if (outValid !== 1'b0 || credits !== 4'd8 || protocolError !== 1'b1) begin
      tests_failed++;
      $display("FAIL viol_sticky got=%b/%0d/%b exp=0/8/1", outValid, credits, protocolError);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) begin
      issueReq = 1'b1;
      cyc();
    end
    issueReq = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pipeValid = 1'b1;
      pipeData  = 16'h0200 + 16'(i);
      cyc();
    end
    pipeValid = 1'b0;
    #1;
    tests_run++;
    if (outValid !== 1'b1 || credits !== 4'd0) begin
      tests_failed++;
      $display("FAIL rstmid_setup got=%b/%0d exp=1/0", outValid, credits);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    tests_run++;
    if (outValid !== 1'b0 || credits !== 4'd8 || protocolError !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_cleared got=%b/%0d/%b exp=0/8/0", outValid, credits, protocolError);
    end
    // A late sample from a pre-reset grant has no owner any more.
    pipeValid = 1'b1;
    pipeData  = 16'h0205;
    cyc();
    pipeValid = 1'b0;
    #1;
    tests_run++;
    if (protocolError !== 1'b1 || outValid !== 1'b0 || credits !== 4'd8) begin
      tests_failed++;
      $display("FAIL rstmid_stale got=%b/%b/%0d exp=1/0/8", protocolError, outValid, credits);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_exhaust();
    test_full_pop_grant();
    test_wrap();
    test_same_cycle();
    test_violation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
